// File: rtl/ex_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_seq_pkg
// Brief    : Shared types and constants for the multi-cycle execute sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ex_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ex_seq_state_e;

    // Widest supported datapath; the constants below are sliced down to XLEN
    localparam int EX_SEQ_MAX_XLEN = 128;

    // Result reported when a unit never completes
    localparam logic [EX_SEQ_MAX_XLEN-1:0] EX_SEQ_ERR_RESULT     = '1;
    // Result reported when the op targets a unit that does not exist
    localparam logic [EX_SEQ_MAX_XLEN-1:0] EX_SEQ_ILLEGAL_RESULT = '0;

endpackage
`default_nettype wire

// File: rtl/ex_seq_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ex_seq_timeout_cnt
// Brief    : Clearable saturating cycle counter. expired_o is high during the
//            LIMIT-th counted cycle, so the owner can leave on that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ex_seq_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int              CNT_W    = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, clear has priority, hold once saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (en_i && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of cycles already spent, so the current cycle
    // is number count+1
    assign expired_o = (count >= CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ex_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ex_mc_sequencer
// Brief    : Dispatches one multi-cycle op at a time to one of N_UNITS
//            functional units, waits for completion (or timeout), registers
//            the result and drives the EX-stage ready.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mc_sequencer
    import ex_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int N_UNITS     = 3,
    parameter int OP_W        = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               issue_valid_i,
    input  logic [((N_UNITS > 1) ? $clog2(N_UNITS) : 1)-1:0]   issue_unit_i,
    input  logic [OP_W-1:0]                                    issue_op_i,
    input  logic [XLEN-1:0]                                    issue_a_i,
    input  logic [XLEN-1:0]                                    issue_b_i,
    input  logic                                               flush_i,
    output logic [N_UNITS-1:0]                                 unit_valid_o,
    output logic [OP_W-1:0]                                    unit_op_o,
    output logic [XLEN-1:0]                                    unit_a_o,
    output logic [XLEN-1:0]                                    unit_b_o,
    input  logic [N_UNITS-1:0]                                 unit_done_i,
    input  logic [N_UNITS*XLEN-1:0]                            unit_result_i,
    output logic [XLEN-1:0]                                    result_o,
    output logic                                               result_valid_o,
    output logic                                               ex_ready_o,
    output logic                                               busy_o,
    output logic                                               error_o
);

    localparam int                UNIT_W     = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [UNIT_W:0]   UNIT_LIMIT = (UNIT_W + 1)'(N_UNITS);

    ex_seq_state_e      state;
    logic [UNIT_W-1:0]  sel;
    logic               issue_legal;
    logic [N_UNITS-1:0] issue_onehot;
    logic               sel_done;
    logic [XLEN-1:0]    sel_result;
    logic               timeout_expired;

    // Unit indices at or above N_UNITS are not attached
    assign issue_legal = ({1'b0, issue_unit_i} < UNIT_LIMIT);

    // Decode the requested unit into the one-hot dispatch vector
    always_comb begin
        issue_onehot = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            issue_onehot[i] = (issue_unit_i == UNIT_W'(i));
        end
    end

    // Select the completion strobe and result of the latched unit only
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (sel == UNIT_W'(i)) begin
                sel_done   = unit_done_i[i];
                sel_result = unit_result_i[i*XLEN +: XLEN];
            end
        end
    end

    // Timeout counter runs only in WAIT and restarts from zero on every op
    if (TIMEOUT_CYC > 0) begin : g_timeout
        ex_seq_timeout_cnt #(
            .LIMIT (TIMEOUT_CYC)
        ) u_timeout_cnt (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (state != ST_WAIT),
            .en_i      (state == ST_WAIT),
            .expired_o (timeout_expired)
        );
    end else begin : g_no_timeout
        assign timeout_expired = 1'b0;
    end

    // Sequencer FSM with registered dispatch, operand and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            sel            <= '0;
            unit_valid_o   <= '0;
            unit_op_o      <= '0;
            unit_a_o       <= '0;
            unit_b_o       <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below
            unit_valid_o   <= '0;
            result_valid_o <= 1'b0;
            error_o        <= 1'b0;
            if (flush_i) begin
                // Flush beats any simultaneous issue, done or timeout
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (issue_valid_i) begin
                            busy_o <= 1'b1;
                            if (issue_legal) begin
                                sel          <= issue_unit_i;
                                unit_op_o    <= issue_op_i;
                                unit_a_o     <= issue_a_i;
                                unit_b_o     <= issue_b_i;
                                unit_valid_o <= issue_onehot;
                                state        <= ST_WAIT;
                            end else begin
                                result_o       <= EX_SEQ_ILLEGAL_RESULT[XLEN-1:0];
                                result_valid_o <= 1'b1;
                                error_o        <= 1'b1;
                                state          <= ST_DONE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (sel_done) begin
                            result_o       <= sel_result;
                            result_valid_o <= 1'b1;
                            state          <= ST_DONE;
                        end else if (timeout_expired) begin
                            result_o       <= EX_SEQ_ERR_RESULT[XLEN-1:0];
                            result_valid_o <= 1'b1;
                            error_o        <= 1'b1;
                            state          <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // The issuing instruction is still presented here
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Combinational ready keeps the existing single-cycle EX handshake
    assign ex_ready_o = ((state == ST_IDLE) && !issue_valid_i) || (state == ST_DONE);

endmodule
`default_nettype wire
